jam_gen: RTL and testbench
==========================

# jam_gen

Parametrised job-assignment engine. It exhaustively enumerates every assignment of N jobs to N workers, reading each cost from an external cost ROM. It reports the minimum total cost, the number of assignments reaching that minimum, and the lexicographically first optimal assignment. It generalises the fixed 8×8 JAM block: configurable N and cost width, a Start/Busy handshake, optional pruning, and a saturating match counter.

## Interface
- N, 8: workers = jobs, legal range 2..8.
- CW, 7: cost word width.
- MCW, 4: MatchCount width; the counter saturates.
- PRUNE, 0: 1 aborts a permutation early once its partial sum exceeds the current best.
- IW (local): max(1, $clog2(N)), the index width.
- SW (local): CW + $clog2(N), the sum width. N=8, CW=7 gives 10.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  synchronous reset, active-low.
- Start  in  1  sampled in IDLE or DONE; launches a run.
- W  out  IW  worker index presented to the cost ROM.
- J  out  IW  job index presented to the cost ROM.
- Cost  in  CW  combinational ROM data for (W,J), valid in the same cycle.
- Busy  out  1  high from the Start edge until Valid.
- Valid  out  1  high in DONE; held until the next accepted Start or reset.
- MinCost  out  SW  minimum total cost.
- MatchCount  out  MCW  count of optimal assignments, saturating at 2^MCW−1.
- BestPerm  out  N*IW  field i (LSBs first) is the job given to worker i.

## Operation
- States: IDLE, ACC, EVAL, DONE.
- Reset (RST_N=0 at an edge) forces IDLE from any state, including mid-run. All outputs go to 0; internal best goes to all-ones.
- IDLE/DONE + Start=1:
  - perm ← identity (0,1,…,N−1); sum ← 0; k ← 0; best ← all-ones; count ← 0.
  - Busy ← 1; Valid ← 0; go to ACC.
  - Result outputs keep their old values until the new Valid.
- ACC:
  - W=k, J=perm[k].
  - Each edge: sum ← sum + Cost (SW-bit add, no overflow by construction); k ← k+1.
  - When k=N−1, go to EVAL.
- PRUNE=1 in ACC: if sum+Cost > best (strictly greater, so ties are still counted), skip EVAL's compare and treat the step as an EVAL with no update.
- EVAL (one cycle):
  - sum<best: best ← sum; count ← 1; bestperm ← perm.
  - sum==best: count ← min(count+1, 2^MCW−1).
  - If perm is the last permutation (strictly descending): go to DONE.
  - Otherwise: perm ← next lexicographic permutation; sum ← 0; k ← 0; go to ACC.
- DONE entry:
  - MinCost ← best, MatchCount ← count, BestPerm ← bestperm.
  - Valid ← 1, Busy ← 0.
- Start while Busy is ignored.
- Ties: the first optimum in lexicographic order is kept.
- W and J are driven 0 in IDLE and DONE.

## Timing
- PRUNE=0: Valid rises exactly N!·(N+1) rising edges after the edge that sampled Start.
  - N=2 → 6 edges.
  - N=3 → 24 edges.
  - N=8 → 362880 edges.
- PRUNE=1: latency is data-dependent and at most the PRUNE=0 value. Results are identical to PRUNE=0.
- Cost is consumed the same cycle W/J are driven, so the ROM must be combinational.
- MinCost, MatchCount and BestPerm change only on the edge that raises Valid.
- Start and RST_N=0 on the same edge: reset wins.

## Structure
- jam_pkg holds:
  - the state enum;
  - the IW and SW width functions;
  - the saturating-increment function.
- One sub-module, jam_next_perm (combinational):
  - input perm;
  - outputs next_perm and is_last.
  - Algorithm: pivot = largest i with p[i]<p[i+1]; swap with the largest j>i such that p[j]>p[i]; reverse the suffix after i.

## Test plan
- N=2, costs {{1,2},{3,4}} → MinCost=5, MatchCount=2, BestPerm=(0,1); Valid 6 edges after Start.
- N=3, all costs 5 → MinCost=15, MatchCount=6; Valid at edge 24; Busy high throughout.
- N=4, MCW=4, all costs 0 → MinCost=0, MatchCount=15 (24 matches, saturated).
- N=8, cost[i][i]=0, others 100 → MinCost=0, MatchCount=1, BestPerm identity, Valid at edge 362880. With PRUNE=1: same results, Valid strictly earlier.
- Reset mid-run: RST_N=0 for one edge at cycle 10 of an N=3 run → all outputs 0 and state IDLE next cycle. A fresh Start gives a correct result 24 edges later.
- Control edge cases:
  - Start pulsed at cycle 5 of a run → ignored, result unchanged.
  - Start in DONE → Valid drops the next cycle and a new run begins.

Source files
------------

// File: rtl/jam_pkg.sv
// rtl/jam_pkg.sv - shared types and width helpers for the job-assignment engine
package jam_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_EVAL,
    S_DONE
  } state_t;

  // Index width: enough bits to name N workers, never less than one.
  function automatic int iw_of(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  // Sum width: N costs of CW bits each can never overflow this.
  function automatic int sw_of(input int n, input int cw);
    return cw + $clog2(n);
  endfunction

  // Increment that sticks at lim instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] lim);
    return (v >= lim) ? lim : v + 32'd1;
  endfunction

endpackage

// File: rtl/jam_gen_if.sv
// rtl/jam_gen_if.sv - start/result handshake and cost ROM bus of jam_gen
interface jam_gen_if #(
  parameter int N   = 8,
  parameter int CW  = 7,
  parameter int MCW = 4
);
  import jam_pkg::*;

  localparam int IW = iw_of(N);
  localparam int SW = sw_of(N, CW);

  logic              Start;
  logic [IW-1:0]     W;
  logic [IW-1:0]     J;
  logic [CW-1:0]     Cost;
  logic              Busy;
  logic              Valid;
  logic [SW-1:0]     MinCost;
  logic [MCW-1:0]    MatchCount;
  logic [N*IW-1:0]   BestPerm;

  // Host side: launches runs and serves the combinational cost ROM.
  modport master (
    output Start, Cost,
    input  W, J, Busy, Valid, MinCost, MatchCount, BestPerm
  );

  // Engine side.
  modport slave (
    input  Start, Cost,
    output W, J, Busy, Valid, MinCost, MatchCount, BestPerm
  );

endinterface

// File: rtl/jam_next_perm.sv
// rtl/jam_next_perm.sv - combinational next-lexicographic-permutation step
module jam_next_perm #(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic [N*IW-1:0] perm,
  output logic [N*IW-1:0] next_perm,
  output logic            is_last
);

  logic [IW-1:0] p [N];
  logic [IW-1:0] s [N];
  logic [IW-1:0] q [N];
  logic [IW-1:0] piv;
  logic [IW-1:0] succ;
  logic [IW:0]   ridx;
  logic          has_piv;

  // Pivot search, swap with rightmost larger element, then reverse the suffix.
  always_comb begin
    piv       = '0;
    succ      = '0;
    ridx      = '0;
    has_piv   = 1'b0;
    next_perm = '0;
    for (int i = 0; i < N; i++) begin
      p[i] = perm[i*IW +: IW];
    end
    for (int i = 0; i < N - 1; i++) begin
      if (p[i] < p[i+1]) begin
        has_piv = 1'b1;
        piv     = IW'(i);
      end
    end
    is_last = !has_piv;
    s = p;
    q = p;
    if (has_piv) begin
      for (int j = 0; j < N; j++) begin
        if (IW'(j) > piv && p[j] > p[piv]) begin
          succ = IW'(j);
        end
      end
      s[piv]  = p[succ];
      s[succ] = p[piv];
      for (int j = 0; j < N; j++) begin
        if (IW'(j) > piv) begin
          // Position j of the suffix takes the element mirrored about its centre.
          ridx = (IW+1)'(N) + {1'b0, piv} - (IW+1)'(j);
          q[j] = s[ridx[IW-1:0]];
        end else begin
          q[j] = s[j];
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      next_perm[i*IW +: IW] = q[i];
    end
  end

endmodule

// File: rtl/jam_gen.sv
// rtl/jam_gen.sv - exhaustive N-by-N job-assignment search over an external cost ROM
module jam_gen
  import jam_pkg::*;
#(
  parameter int N     = 8,
  parameter int CW    = 7,
  parameter int MCW   = 4,
  parameter int PRUNE = 0
) (
  input  logic      CLK,
  input  logic      RST_N,
  jam_gen_if.slave  bus
);

  localparam int IW = iw_of(N);
  localparam int SW = sw_of(N, CW);

  function automatic logic [N*IW-1:0] ident_perm();
    logic [N*IW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      r[i*IW +: IW] = IW'(i);
    end
    return r;
  endfunction

  localparam logic [N*IW-1:0] IDENT = ident_perm();

  state_t          state;
  logic [N*IW-1:0] perm;
  logic [N*IW-1:0] best_perm;
  logic [N*IW-1:0] next_perm;
  logic            is_last;
  logic [SW-1:0]   sum;
  logic [SW-1:0]   best;
  logic [SW-1:0]   acc;
  logic [IW-1:0]   k;
  logic [MCW-1:0]  count;
  logic            prune_hit;
  logic            step_done;
  logic [SW-1:0]   upd_best;
  logic [MCW-1:0]  upd_count;
  logic [N*IW-1:0] upd_bperm;

  jam_next_perm #(
    .N  (N),
    .IW (IW)
  ) u_next_perm (
    .perm      (perm),
    .next_perm (next_perm),
    .is_last   (is_last)
  );

  assign acc       = sum + SW'(bus.Cost);
  // Strictly greater, so a partial sum equal to the best still reaches the tie count.
  assign prune_hit = (PRUNE != 0) && (state == S_ACC) && (acc > best);
  assign step_done = (state == S_EVAL) || prune_hit;
  assign bus.W     = (state == S_ACC) ? k : '0;
  assign bus.J     = (state == S_ACC) ? perm[k*IW +: IW] : '0;

  // Best/count/permutation after this cycle's evaluation; a pruned step leaves them alone.
  always_comb begin
    upd_best  = best;
    upd_count = count;
    upd_bperm = best_perm;
    if (state == S_EVAL) begin
      if (sum < best) begin
        upd_best  = sum;
        upd_count = MCW'(1);
        upd_bperm = perm;
      end else if (sum == best) begin
        upd_count = MCW'(sat_inc(32'(count), 32'({MCW{1'b1}})));
      end
    end
  end

  // Run controller: accumulate one permutation, evaluate, step to the next, publish on the last.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state          <= S_IDLE;
      perm           <= '0;
      sum            <= '0;
      k              <= '0;
      best           <= '1;
      count          <= '0;
      best_perm      <= '0;
      bus.Busy       <= 1'b0;
      bus.Valid      <= 1'b0;
      bus.MinCost    <= '0;
      bus.MatchCount <= '0;
      bus.BestPerm   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.Start) begin
            perm      <= IDENT;
            sum       <= '0;
            k         <= '0;
            best      <= '1;
            count     <= '0;
            bus.Busy  <= 1'b1;
            bus.Valid <= 1'b0;
            state     <= S_ACC;
          end
        end
        S_ACC, S_EVAL: begin
          if (step_done) begin
            best      <= upd_best;
            count     <= upd_count;
            best_perm <= upd_bperm;
            if (is_last) begin
              bus.MinCost    <= upd_best;
              bus.MatchCount <= upd_count;
              bus.BestPerm   <= upd_bperm;
              bus.Valid      <= 1'b1;
              bus.Busy       <= 1'b0;
              state          <= S_DONE;
            end else begin
              perm  <= next_perm;
              sum   <= '0;
              k     <= '0;
              state <= S_ACC;
            end
          end else begin
            sum <= acc;
            k   <= k + IW'(1);
            if (k == IW'(N - 1)) begin
              state <= S_EVAL;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jam_gen.sv
// tb/tb_jam_gen.sv - self-checking bench for jam_gen against a brute-force assignment model
module tb_jam_gen;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  int   sel;
  bit   mon_en;
  logic [6:0] cost [8][8];

  int pass_cnt  = 0;
  int total_cnt = 0;

  int exp_min, exp_cnt, exp_perm, exp_lat;

  bit m_run [3];
  bit m_busy [3];
  bit m_valid [3];
  int m_left [3];
  int m_min [3];
  int m_cnt [3];
  int m_perm [3];

  always #5 clk = ~clk;

  jam_gen_if #(.N(2), .CW(7), .MCW(4)) i2 ();
  jam_gen_if #(.N(3), .CW(7), .MCW(4)) i3 ();
  jam_gen_if #(.N(4), .CW(7), .MCW(4)) i4 ();
  jam_gen_if #(.N(4), .CW(7), .MCW(4)) i4p ();

  jam_gen #(.N(2), .CW(7), .MCW(4), .PRUNE(0)) d2  (.CLK(clk), .RST_N(rst_n), .bus(i2));
  jam_gen #(.N(3), .CW(7), .MCW(4), .PRUNE(0)) d3  (.CLK(clk), .RST_N(rst_n), .bus(i3));
  jam_gen #(.N(4), .CW(7), .MCW(4), .PRUNE(0)) d4  (.CLK(clk), .RST_N(rst_n), .bus(i4));
  jam_gen #(.N(4), .CW(7), .MCW(4), .PRUNE(1)) d4p (.CLK(clk), .RST_N(rst_n), .bus(i4p));

  assign i2.Start  = start && (sel == 0);
  assign i3.Start  = start && (sel == 1);
  assign i4.Start  = start && (sel == 2);
  assign i4p.Start = start && (sel == 2);
  assign i2.Cost   = cost[3'(i2.W)][3'(i2.J)];
  assign i3.Cost   = cost[3'(i3.W)][3'(i3.J)];
  assign i4.Cost   = cost[3'(i4.W)][3'(i4.J)];
  assign i4p.Cost  = cost[3'(i4p.W)][3'(i4p.J)];

  logic        cb, cv;
  logic [15:0] cmin, cperm;
  logic [3:0]  ccnt;
  logic [2:0]  cw, cj;

  always_comb begin
    case (sel)
      0: begin
        cb = i2.Busy; cv = i2.Valid; cmin = 16'(i2.MinCost); ccnt = i2.MatchCount;
        cperm = 16'(i2.BestPerm); cw = 3'(i2.W); cj = 3'(i2.J);
      end
      1: begin
        cb = i3.Busy; cv = i3.Valid; cmin = 16'(i3.MinCost); ccnt = i3.MatchCount;
        cperm = 16'(i3.BestPerm); cw = 3'(i3.W); cj = 3'(i3.J);
      end
      default: begin
        cb = i4.Busy; cv = i4.Valid; cmin = 16'(i4.MinCost); ccnt = i4.MatchCount;
        cperm = 16'(i4.BestPerm); cw = 3'(i4.W); cj = 3'(i4.J);
      end
    endcase
  end

  function automatic void chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endfunction

  // Enumerate all N^N index tuples in lexicographic order, keep only permutations.
  function automatic void model(input int n);
    int tuples, code, tmp, s, iw, f, cnt;
    int p [8];
    bit used [8];
    bit ok;
    iw = (n <= 2) ? 1 : ((n <= 4) ? 2 : 3);
    tuples = 1;
    f = 1;
    for (int i = 0; i < n; i++) begin
      tuples = tuples * n;
      f = f * (i + 1);
    end
    exp_lat = f * (n + 1);
    exp_min = 32'h7fffffff;
    cnt = 0;
    exp_perm = 0;
    for (code = 0; code < tuples; code++) begin
      tmp = code;
      for (int i = n - 1; i >= 0; i--) begin
        p[i] = tmp % n;
        tmp = tmp / n;
      end
      for (int i = 0; i < 8; i++) used[i] = 1'b0;
      ok = 1'b1;
      for (int i = 0; i < n; i++) begin
        if (used[p[i]]) ok = 1'b0;
        used[p[i]] = 1'b1;
      end
      if (ok) begin
        s = 0;
        for (int i = 0; i < n; i++) s = s + int'(cost[i][p[i]]);
        if (s < exp_min) begin
          exp_min = s;
          cnt = 1;
          exp_perm = 0;
          for (int i = 0; i < n; i++) exp_perm = exp_perm | (p[i] << (i * iw));
        end else if (s == exp_min) begin
          cnt++;
        end
      end
    end
    exp_cnt = (cnt > 15) ? 15 : cnt;
  endfunction

  // Expected observable behaviour of each non-pruning engine, cycle by cycle.
  always @(posedge clk) begin
    for (int s = 0; s < 3; s++) begin
      if (!rst_n) begin
        m_run[s] = 1'b0; m_busy[s] = 1'b0; m_valid[s] = 1'b0;
        m_min[s] = 0; m_cnt[s] = 0; m_perm[s] = 0; m_left[s] = 0;
      end else if (m_run[s]) begin
        m_left[s]--;
        if (m_left[s] == 0) begin
          m_run[s] = 1'b0; m_busy[s] = 1'b0; m_valid[s] = 1'b1;
          m_min[s] = exp_min; m_cnt[s] = exp_cnt; m_perm[s] = exp_perm;
        end
      end else if (start && sel == s) begin
        m_run[s] = 1'b1; m_busy[s] = 1'b1; m_valid[s] = 1'b0; m_left[s] = exp_lat;
      end
    end
  end

  // Single compare process for the selected engine.
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      chk("busy", int'(cb), int'(m_busy[sel]));
      chk("valid", int'(cv), int'(m_valid[sel]));
      chk("min_cost", int'(cmin), m_min[sel]);
      chk("match_count", int'(ccnt), m_cnt[sel]);
      chk("best_perm", int'(cperm), m_perm[sel]);
      if (!m_busy[sel]) begin
        chk("w_idle", int'(cw), 0);
        chk("j_idle", int'(cj), 0);
      end
    end
  end

  task automatic go();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int plat);
    lat = 0;
    plat = -1;
    while (!cv && lat < 5000) begin
      if (plat < 0 && i4p.Valid) plat = lat;
      @(negedge clk);
      lat++;
    end
    if (plat < 0 && i4p.Valid) plat = lat;
    if (!cv) begin
      total_cnt++;
      $display("FAIL timeout: got no Valid after %0d edges, expected Valid", lat);
    end
  endtask

  task automatic chk_prune(input string tag, input int plat, input int lat);
    chk({tag, "_p_min"}, int'(i4p.MinCost), exp_min);
    chk({tag, "_p_cnt"}, int'(i4p.MatchCount), exp_cnt);
    chk({tag, "_p_perm"}, int'(i4p.BestPerm), exp_perm);
    chk({tag, "_p_lat_ok"}, int'(plat >= 0 && plat <= lat), 1);
  endtask

  initial begin
    int lat, plat;
    rst_n = 1'b0;
    start = 1'b0;
    sel = 0;
    mon_en = 1'b0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) cost[i][j] = 7'd0;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    chk("rst_valid", int'(cv), 0);
    chk("rst_busy", int'(cb), 0);
    chk("rst_min", int'(cmin), 0);
    rst_n = 1'b1;

    // N=2, costs {{1,2},{3,4}}: both assignments cost 5.
    sel = 0;
    cost[0][0] = 7'd1; cost[0][1] = 7'd2; cost[1][0] = 7'd3; cost[1][1] = 7'd4;
    model(2);
    go();
    wait_done(lat, plat);
    chk("n2_lat", lat, 6);
    chk("n2_min", int'(cmin), 5);
    chk("n2_cnt", int'(ccnt), 2);
    chk("n2_perm", int'(cperm), 2);

    // N=3, all costs 5: every one of the 6 assignments ties at 15.
    sel = 1;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) cost[i][j] = 7'd5;
    model(3);
    go();
    wait_done(lat, plat);
    chk("n3_lat", lat, 24);
    chk("n3_min", int'(cmin), 15);
    chk("n3_cnt", int'(ccnt), 6);

    // N=3 distinct costs; unique optimum (1,0,2) = 1+2+2 = 5. Extra Start at cycle 5 is ignored.
    cost[0][0] = 7'd4; cost[0][1] = 7'd1; cost[0][2] = 7'd3;
    cost[1][0] = 7'd2; cost[1][1] = 7'd0; cost[1][2] = 7'd5;
    cost[2][0] = 7'd3; cost[2][1] = 7'd2; cost[2][2] = 7'd2;
    model(3);
    go();
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, plat);
    chk("ign_lat", lat + 5, 24);
    chk("ign_min", int'(cmin), 5);
    chk("ign_cnt", int'(ccnt), 1);
    chk("ign_perm", int'(cperm), 33);

    // Start while in DONE restarts; Valid must drop immediately.
    go();
    chk("restart_valid", int'(cv), 0);
    chk("restart_busy", int'(cb), 1);
    wait_done(lat, plat);
    chk("restart_lat", lat, 24);

    // Reset on edge 10 of a run, then a fresh run.
    go();
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_busy", int'(cb), 0);
    chk("midrst_min", int'(cmin), 0);
    chk("midrst_perm", int'(cperm), 0);
    go();
    wait_done(lat, plat);
    chk("post_rst_lat", lat, 24);
    chk("post_rst_min", int'(cmin), 5);
    chk("post_rst_perm", int'(cperm), 33);

    // N=4, all costs 0: 24 ties, counter saturates at 15.
    sel = 2;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) cost[i][j] = 7'd0;
    model(4);
    go();
    wait_done(lat, plat);
    chk("n4z_lat", lat, 120);
    chk("n4z_min", int'(cmin), 0);
    chk("n4z_cnt", int'(ccnt), 15);
    chk("n4z_perm", int'(cperm), 228);
    chk_prune("n4z", plat, lat);

    // N=4 diagonal 0, others 100: identity is the only optimum; pruning must finish sooner.
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) cost[i][j] = (i == j) ? 7'd0 : 7'd100;
    model(4);
    go();
    wait_done(lat, plat);
    chk("diag_lat", lat, 120);
    chk("diag_min", int'(cmin), 0);
    chk("diag_cnt", int'(ccnt), 1);
    chk("diag_perm", int'(cperm), 228);
    chk_prune("diag", plat, lat);
    chk("diag_p_earlier", int'(plat >= 0 && plat < lat), 1);

    // N=4 mixed costs with ties, checked against the model only.
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) cost[i][j] = 7'((i * 3 + j * 5) % 7);
    model(4);
    go();
    wait_done(lat, plat);
    chk("mix_lat", lat, 120);
    chk_prune("mix", plat, lat);

    mon_en = 1'b0;
    @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
